// File: rtl/jtframe_dma_pkg.sv
// jtframe_dma_pkg: shared FSM encoding, channel-index width and priority helper
// for the jtframe_busdma engine.
package jtframe_dma_pkg;
  localparam int CHW = 2;
  typedef enum logic [2:0] {IDLE, REQ, XFER, FLUSH, REL} state_t;
  function automatic logic [CHW-1:0] prio_enc(input logic [3:0] req);
    return req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/jtframe_busdma_arb.sv
// jtframe_busdma_arb: per-channel go edge detect, pending latches and
// lowest-index-first selection.
module jtframe_busdma_arb
  import jtframe_dma_pkg::*;
#(
  parameter int CH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CH-1:0]  go_i,
  input  logic [CH-1:0]  clr_i,
  output logic           any_o,
  output logic [CHW-1:0] sel_o
);
  logic [CH-1:0] go_q, pend_q;
  logic [3:0]    req;
  // a fresh edge wins over the clear so a re-trigger during selection is kept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      go_q   <= '0;
      pend_q <= '0;
    end else begin
      go_q   <= go_i;
      pend_q <= (pend_q & ~clr_i) | (go_i & ~go_q);
    end
  always_comb begin
    req          = '0;
    req[CH-1:0]  = pend_q;
  end
  assign any_o = |pend_q;
  assign sel_o = prio_enc(req);
endmodule

// File: rtl/jtframe_busdma.sv
// jtframe_busdma: multi-channel bus-mastering block copier from CPU RAM to a private buffer.
// Define JTFRAME_DMA_VBL_EN to hold new transfers until vertical blank (LVBL low).
module jtframe_busdma
  import jtframe_dma_pkg::*;
#(
  parameter int CH = 2,
  parameter int AW = 12,
  parameter int DW = 8,
  parameter int LW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            LVBL,
  input  logic [CH-1:0]   go,
  input  logic [CH*AW-1:0] cfg_base,
  input  logic [CH*LW-1:0] cfg_len,
  output logic            busrq_n,
  input  logic            busak_n,
  output logic [AW-1:0]   src_addr,
  output logic            src_cs,
  input  logic [DW-1:0]   src_dout,
  output logic [LW-1:0]   dst_addr,
  output logic [DW-1:0]   dst_din,
  output logic            dst_we,
  output logic [1:0]      dst_ch,
  output logic            busy,
  output logic [CH-1:0]   done
);
  state_t         state_q;
  logic           any, gate, take, stall_q;
  logic           busrq_n_q, cs_q, we_q, busy_q;
  logic [CHW-1:0] sel, ch_q;
  logic [CH-1:0]  clr, done_q;
  logic [AW-1:0]  base_sel, base_q, addr_q;
  logic [LW-1:0]  len_sel, len_q, cnt_q, cnt_m1, daddr_q;
  logic [DW-1:0]  din_q;

  jtframe_busdma_arb #(.CH(CH)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .go_i  (go),
    .clr_i (clr),
    .any_o (any),
    .sel_o (sel)
  );

`ifdef JTFRAME_DMA_VBL_EN
  assign gate = ~LVBL;
`else
  logic vbl_unused;
  assign vbl_unused = LVBL;
  assign gate       = 1'b1;
`endif

  assign base_sel = cfg_base[int'(sel)*AW +: AW];
  assign len_sel  = cfg_len[int'(sel)*LW +: LW];
  // empty blocks finish at clk rate; real transfers start on a cen step
  assign take     = state_q == IDLE && any && gate && (len_sel == '0 || cen);
  assign clr      = take ? CH'(1) << sel : '0;
  assign cnt_m1   = cnt_q - 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      busrq_n_q <= 1'b1;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      addr_q    <= '0;
      daddr_q   <= '0;
      din_q     <= '0;
      ch_q      <= '0;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      stall_q   <= 1'b0;
    end else begin
      done_q <= '0;
      we_q   <= 1'b0;
      case (state_q)
        IDLE: if (take) begin
          ch_q    <= sel;
          base_q  <= base_sel;
          len_q   <= len_sel;
          cnt_q   <= '0;
          stall_q <= 1'b0;
          if (len_sel == '0) done_q <= clr;
          else begin
            state_q   <= REQ;
            busrq_n_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        REQ: if (cen && !busak_n) state_q <= XFER;
        XFER: if (cen) begin
          if (busak_n) begin
            stall_q <= 1'b1;
            cs_q    <= 1'b0;
          end else if (stall_q && cnt_q != '0) begin
            // the word read before the stall was lost with the bus: fetch it again
            stall_q <= 1'b0;
            addr_q  <= base_q + AW'(cnt_m1);
            cs_q    <= 1'b1;
          end else begin
            stall_q <= 1'b0;
            addr_q  <= base_q + AW'(cnt_q);
            cs_q    <= 1'b1;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q != '0) begin
              we_q    <= 1'b1;
              daddr_q <= cnt_m1;
              din_q   <= src_dout;
            end
            if (cnt_q + 1'b1 == len_q) state_q <= FLUSH;
          end
        end
        FLUSH: if (cen) begin
          we_q      <= 1'b1;
          daddr_q   <= cnt_m1;
          din_q     <= src_dout;
          cs_q      <= 1'b0;
          busrq_n_q <= 1'b1;
          state_q   <= REL;
        end
        REL: if (cen && busak_n) begin
          done_q  <= CH'(1) << ch_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end

  assign busrq_n  = busrq_n_q;
  assign src_addr = addr_q;
  assign src_cs   = cs_q;
  assign dst_addr = daddr_q;
  assign dst_din  = din_q;
  assign dst_we   = we_q;
  assign dst_ch   = ch_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_jtframe_busdma.sv
// tb_jtframe_busdma: randomized scenarios for jtframe_busdma against a queue-based
// model of the expected copies; set JTFRAME_DMA_VBL_EN to also cover the blank gate.
module tb_jtframe_busdma;
  localparam int CH = 2, AW = 12, DW = 8, LW = 9;
  logic clk = 0, rst_n = 0, cen = 1, LVBL = 0, busak_n = 1;
  logic busrq_n, src_cs, dst_we, busy;
  logic [CH-1:0] go = '0, done;
  logic [CH*AW-1:0] cfg_base = '0;
  logic [CH*LW-1:0] cfg_len = '0;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_dout, dst_din;
  logic [LW-1:0] dst_addr;
  logic [1:0] dst_ch;
  logic [DW-1:0] mem [0:4095];
  int total = 0, bad = 0, cyc = 0, ack_delay = 2, lag = 0, nfall = 0;
  bit cen_all = 1, cpu_hold = 0, cen_s = 1, ak_s = 1, prev_rq = 1;
  typedef struct {int ch; int idx; int data; int cyc; bit ak;} wr_t;
  wr_t wq[$], eq[$];
  int rq[$], rcyc[$], dq[$];

  jtframe_busdma #(.CH(CH), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .go(go),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .busrq_n(busrq_n), .busak_n(busak_n),
    .src_addr(src_addr), .src_cs(src_cs), .src_dout(src_dout), .dst_addr(dst_addr),
    .dst_din(dst_din), .dst_we(dst_we), .dst_ch(dst_ch), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign src_dout = mem[src_addr];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    cen_s <= cen;
    ak_s <= busak_n;
  end

  always @(negedge clk) cen = cen_all ? 1'b1 : 1'($urandom_range(0, 1));

  // CPU: follows busrq_n after ack_delay clocks; cpu_hold steals the bus back
  always @(negedge clk) begin
    if (cpu_hold) busak_n = 1'b1;
    else if (busak_n != busrq_n) begin
      if (lag >= ack_delay) begin
        busak_n = busrq_n;
        lag = 0;
      end else lag++;
    end else lag = 0;
  end

  always @(negedge clk) begin
    if (dst_we) wq.push_back('{int'(dst_ch), int'(dst_addr), int'(dst_din), cyc, ak_s});
    if (cen_s && src_cs) begin
      rq.push_back(int'(src_addr));
      rcyc.push_back(cyc);
    end
    if (done != '0) dq.push_back(int'({busy, busak_n, done}));
    if (prev_rq && !busrq_n) nfall++;
    prev_rq = busrq_n;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void clear_logs();
    wq.delete(); eq.delete(); rq.delete(); rcyc.delete(); dq.delete();
    nfall = 0;
  endfunction

  function automatic void set_ch(int ch, int base, int len);
    cfg_base[ch*AW +: AW] = AW'(base);
    cfg_len[ch*LW +: LW]  = LW'(len);
  endfunction

  function automatic void model(int ch, int base, int len);
    for (int i = 0; i < len; i++) eq.push_back('{ch, i, int'(mem[(base + i) % 4096]), 0, 1'b0});
  endfunction

  function automatic int first_diff();
    if (wq.size() != eq.size()) return -2;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i].ch != eq[i].ch || wq[i].idx != eq[i].idx || wq[i].data != eq[i].data) return i;
    return -1;
  endfunction

  task automatic pulse(input logic [CH-1:0] mask);
    @(negedge clk) go = mask;
    @(negedge clk) go = '0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && dq.size() < n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({busrq_n, src_cs, dst_we, busy, done, src_addr, dst_addr, dst_din, dst_ch} !== {1'b1, 3'b0, 2'b0, 12'h0, 9'h0, 8'h0, 2'b0}) begin
      bad++;
      $display("FAIL reset: got rq=%b cs=%b we=%b busy=%b done=%b sa=%h da=%h din=%h ch=%0d want rq=1 others 0",
               busrq_n, src_cs, dst_we, busy, done, src_addr, dst_addr, dst_din, dst_ch);
    end
    @(negedge clk) rst_n = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    cen_all = 1; ack_delay = 2;
    clear_logs();
    set_ch(0, 'h100, 4);
    model(0, 'h100, 4);
    @(negedge clk) go = 2'b01;
    @(negedge clk) go = '0;
    @(negedge clk);
    total++;
    if (busrq_n !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency: got busrq_n=%b busy=%b want 0 1", busrq_n, busy);
    end
    wait_done(1, 200);
    total++;
    if (dq.size() != 1 || dq[0] != 5) begin
      bad++;
      $display("FAIL basic_done: got %0d pulses first=%0h want 1 pulse 5", dq.size(), dq.size() ? dq[0] : -1);
    end
    ok = rq.size() == 4;
    for (int i = 0; ok && i < 4; i++) ok = rq[i] == 'h100 + i;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_reads: got %0d reads first=%0h want 100..103", rq.size(), rq.size() ? rq[0] : -1);
    end
    total++;
    if (first_diff() != -1) begin
      bad++;
      $display("FAIL basic_writes: diff at %0d, got %0d writes want %0d", first_diff(), wq.size(), eq.size());
    end
    total++;
    if (wq.size() != 4 || rcyc.size() == 0 || wq[wq.size()-1].cyc - rcyc[0] != 4) begin
      bad++;
      $display("FAIL basic_span: got %0d writes span=%0d want 4 writes span 4", wq.size(),
               (wq.size() && rcyc.size()) ? wq[wq.size()-1].cyc - rcyc[0] : -1);
    end
  endtask

  task automatic test_same_clk();
    int b0, b1, l0, l1;
    cen_all = 0; ack_delay = 1;
    b0 = $urandom_range(0, 4095); b1 = $urandom_range(0, 4095);
    l0 = $urandom_range(1, 16);   l1 = $urandom_range(1, 16);
    clear_logs();
    set_ch(0, b0, l0); set_ch(1, b1, l1);
    model(0, b0, l0); model(1, b1, l1);
    pulse(2'b11);
    wait_done(2, 3000);
    total++;
    if (dq.size() != 2 || dq[0] != 5 || dq[1] != 6) begin
      bad++;
      $display("FAIL same_done: got %0d pulses [%0h %0h] want [5 6]", dq.size(),
               dq.size() > 0 ? dq[0] : -1, dq.size() > 1 ? dq[1] : -1);
    end
    total++;
    if (nfall != 2) begin
      bad++;
      $display("FAIL same_requests: got %0d bus requests want 2", nfall);
    end
    total++;
    if (first_diff() != -1) begin
      bad++;
      $display("FAIL same_writes: diff at %0d, got %0d writes want %0d", first_diff(), wq.size(), eq.size());
    end
  endtask

  task automatic test_wrap();
    int exp_a [4];
    bit ok;
    exp_a = '{'hFFE, 'hFFF, 'h000, 'h001};
    cen_all = 1; ack_delay = 2;
    clear_logs();
    set_ch(0, 'hFFE, 4);
    model(0, 'hFFE, 4);
    pulse(2'b01);
    wait_done(1, 200);
    ok = rq.size() == 4;
    for (int i = 0; ok && i < 4; i++) ok = rq[i] == exp_a[i];
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wrap_reads: got %0d reads third=%0h want FFE FFF 000 001", rq.size(), rq.size() > 2 ? rq[2] : -1);
    end
    total++;
    if (first_diff() != -1) begin
      bad++;
      $display("FAIL wrap_writes: diff at %0d, got %0d writes want %0d", first_diff(), wq.size(), eq.size());
    end
  endtask

  task automatic test_zero_len();
    bit seen = 0;
    cen_all = 1;
    clear_logs();
    set_ch(1, $urandom_range(0, 4095), 0);
    @(negedge clk) go = 2'b10;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk) go = '0;
      if (done === 2'b10) seen = 1;
    end
    repeat (6) @(negedge clk);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL zero_done_latency: got no done[1] within 2 clk want pulse");
    end
    total++;
    if (nfall != 0 || busrq_n !== 1'b1) begin
      bad++;
      $display("FAIL zero_busrq: got %0d requests busrq_n=%b want 0 and 1", nfall, busrq_n);
    end
    total++;
    if (dq.size() != 1 || wq.size() != 0) begin
      bad++;
      $display("FAIL zero_pulses: got %0d done %0d writes want 1 and 0", dq.size(), wq.size());
    end
  endtask

  task automatic test_stall();
    int b, nak = 0;
    cen_all = 1; ack_delay = 1;
    b = $urandom_range(0, 4095);
    clear_logs();
    set_ch(1, b, 12);
    model(1, b, 12);
    pulse(2'b10);
    for (int i = 0; i < 300 && wq.size() < 4; i++) @(negedge clk);
    cpu_hold = 1;
    repeat (3) @(negedge clk);
    cpu_hold = 0;
    wait_done(1, 300);
    foreach (wq[i]) if (wq[i].ak) nak++;
    total++;
    if (nak != 0) begin
      bad++;
      $display("FAIL stall_we: got %0d writes while bus lost want 0", nak);
    end
    total++;
    if (first_diff() != -1) begin
      bad++;
      $display("FAIL stall_writes: diff at %0d, got %0d writes want %0d", first_diff(), wq.size(), eq.size());
    end
    total++;
    if (rq.size() != 13) begin
      bad++;
      $display("FAIL stall_reissue: got %0d reads want 13", rq.size());
    end
    total++;
    if (dq.size() != 1 || dq[0] != 6) begin
      bad++;
      $display("FAIL stall_done: got %0d pulses first=%0h want 1 pulse 6", dq.size(), dq.size() ? dq[0] : -1);
    end
  endtask

  task automatic test_rst_mid();
    int b;
    cen_all = 1; ack_delay = 2;
    b = $urandom_range(0, 4095);
    clear_logs();
    set_ch(0, b, 30);
    pulse(2'b01);
    for (int i = 0; i < 300 && wq.size() < 3; i++) @(negedge clk);
    #2 rst_n = 0;
    #1;
    total++;
    if (busrq_n !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got busrq_n=%b busy=%b want 1 0", busrq_n, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    total++;
    if (dq.size() != 0) begin
      bad++;
      $display("FAIL rst_no_done: got %0d done pulses want 0", dq.size());
    end
    clear_logs();
    set_ch(0, b, 5);
    model(0, b, 5);
    pulse(2'b01);
    wait_done(1, 300);
    total++;
    if (first_diff() != -1) begin
      bad++;
      $display("FAIL rst_rerun_writes: diff at %0d, got %0d writes want %0d", first_diff(), wq.size(), eq.size());
    end
    total++;
    if (dq.size() != 1 || dq[0] != 5) begin
      bad++;
      $display("FAIL rst_rerun_done: got %0d pulses first=%0h want 1 pulse 5", dq.size(), dq.size() ? dq[0] : -1);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int ed[$];
      int nreq = 0;
      logic [CH-1:0] mask;
      cen_all = 1'($urandom_range(0, 1));
      ack_delay = $urandom_range(0, 4);
      mask = CH'($urandom_range(1, 3));
      clear_logs();
      for (int c = 0; c < CH; c++) begin
        int b = $urandom_range(0, 4095);
        int l = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20);
        set_ch(c, b, l);
        if (mask[c]) begin
          model(c, b, l);
          ed.push_back(4 | (1 << c));
          if (l != 0) nreq++;
        end
      end
      pulse(mask);
      wait_done(ed.size(), 3000);
      total++;
      if (dq != ed) begin
        bad++;
        $display("FAIL rand%0d_done: got %0d pulses first=%0h want %0d first=%0h", it, dq.size(),
                 dq.size() ? dq[0] : -1, ed.size(), ed[0]);
      end
      total++;
      if (first_diff() != -1) begin
        bad++;
        $display("FAIL rand%0d_writes: diff at %0d, got %0d writes want %0d", it, first_diff(), wq.size(), eq.size());
      end
      total++;
      if (nfall != nreq) begin
        bad++;
        $display("FAIL rand%0d_requests: got %0d want %0d", it, nfall, nreq);
      end
    end
  endtask

`ifdef JTFRAME_DMA_VBL_EN
  task automatic test_vbl();
    cen_all = 1; ack_delay = 1;
    LVBL = 1;
    clear_logs();
    set_ch(0, 'h200, 3);
    model(0, 'h200, 3);
    pulse(2'b01);
    repeat (20) @(negedge clk);
    total++;
    if (nfall != 0) begin
      bad++;
      $display("FAIL vbl_hold: got %0d requests during active video want 0", nfall);
    end
    LVBL = 0;
    wait_done(1, 300);
    total++;
    if (first_diff() != -1 || dq.size() != 1) begin
      bad++;
      $display("FAIL vbl_run: got %0d writes %0d done want %0d and 1", wq.size(), dq.size(), eq.size());
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
    test_reset();
    test_basic();
    test_same_clk();
    test_wrap();
    test_zero_len();
    test_stall();
    test_rst_mid();
    test_random();
`ifdef JTFRAME_DMA_VBL_EN
    test_vbl();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtframe_busdma.md
# jtframe_busdma

Multi-channel bus-mastering DMA engine for Z80-based boards. It sits beside the main CPU glue and replaces the single hard-wired `dma_go` copy path. Each channel requests the CPU bus through `busrq_n`/`busak_n`, copies a block of words from shared CPU-side RAM into a private destination buffer (object/palette RAM), then releases the bus. Channel count, address width, data width and length width are parameters; start address and length are runtime inputs.

## Interface
- `CH`, 2: number of channels, 1..4.
- `AW`, 12: source address width.
- `DW`, 8: data width.
- `LW`, 9: length/count width; maximum block is 2^LW−1 words.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cen` in 1: step enable; all bus/transfer steps advance only on `cen`.
- `LVBL` in 1: vertical blank, active-low. Used only with the macro.
- `go` in CH: per-channel trigger. Rising edge is detected at `clk` rate.
- `cfg_base` in CH*AW: per-channel source start address, channel 0 in the LSBs.
- `cfg_len` in CH*LW: per-channel word count.
- `busrq_n` out 1: bus request to the CPU.
- `busak_n` in 1: bus acknowledge from the CPU.
- `src_addr` out AW: source read address.
- `src_cs` out 1: source read strobe.
- `src_dout` in DW: source data, valid one `cen` after the address.
- `dst_addr` out LW: destination word index, starting at 0.
- `dst_din` out DW: destination write data.
- `dst_we` out 1: destination write, one `clk` wide.
- `dst_ch` out 2: active channel index.
- `busy` out 1: high from bus request until release completes.
- `done` out CH: one-`clk` completion pulse per channel.

## Operation
- Pending latch per channel. A rising edge on `go[i]` sets `pend[i]`.
  - Edge while `pend[i]` is already set: ignored.
  - Edge while channel i is active: sets `pend[i]`, so the channel re-runs after the current transfer.
- Arbitration happens in IDLE only: the lowest pending index wins. On selection the engine latches base/len and clears `pend[i]`.
- If the latched len is 0: no bus request. `done[i]` pulses, and the engine returns to IDLE.
- FSM:
  - IDLE → REQ: pending channel selected (and gate satisfied, see Configuration).
  - REQ: `busrq_n`=0; wait until `busak_n`=0 is sampled on `cen` → XFER.
  - XFER: each `cen` drives `src_addr`=base+cnt with `src_cs`=1. From the second `cen` on, it writes the previous word: `dst_addr`=cnt−1, `dst_din`=`src_dout`, `dst_we`=1. When cnt reaches len → FLUSH.
  - FLUSH: one `cen`. Writes the last word and sets `src_cs`=0 → REL.
  - REL: `busrq_n`=1; wait for `busak_n`=1 on `cen`. Then pulse `done[ch]` → IDLE.
- Address arithmetic: base+cnt is computed modulo 2^AW, so the source address wraps past the top of the map.
- Bus lost in XFER (`busak_n`=1 sampled): stall. Hold cnt and `src_addr`, force `dst_we`=0, and re-issue the current read once `busak_n` returns low.
- `busak_n` low while in IDLE: ignored.

## Timing
- Reset values: `busrq_n`=1, `src_cs`=0, `dst_we`=0, `busy`=0, `done`=0, `src_addr`=0, `dst_addr`=0, `dst_din`=0, `dst_ch`=0, all pend=0, state IDLE.
- `rst_n` low mid-transfer releases `busrq_n` immediately (asynchronously) and discards the transfer. No `done` pulse is emitted.
- Latency from `go` edge to `busrq_n` low: first `cen` after the edge is registered.
- XFER plus FLUSH take exactly len+1 `cen` when the bus is not lost.
- `dst_we` is asserted for a single `clk` on the qualifying `cen` cycle.
- `busy` rises with `busrq_n` low and falls in the same cycle as the `done` pulse.

## Configuration
- `JTFRAME_DMA_VBL_EN` defined: the IDLE→REQ transition additionally requires `LVBL`=0. Pending channels wait through active video. A transfer already running continues past the end of blank.
- Not defined: `LVBL` is ignored and requests start immediately.

## Structure
- Shared package `jtframe_dma_pkg`:
  - state enum {IDLE, REQ, XFER, FLUSH, REL}
  - channel-index width constant
  - a priority-encode function
- One sub-module, `jtframe_busdma_arb`: per-channel edge detect, pending latches and lowest-index priority encoder.
- Everything else is flat in `jtframe_busdma`.

## Test plan
- CH=2, base0=0x100, len0=4, pulse `go[0]`, CPU acks 2 `cen` later → src reads 0x100..0x103; `dst_we` on indices 0..3 with the matching data; `done[0]` after `busak_n` returns high.
- `go[0]` and `go[1]` in the same `clk` → channel 0 completes first, then channel 1 re-requests the bus; two `done` pulses in order 0, 1.
- base=0xFFE, len=4 → src addresses 0xFFE, 0xFFF, 0x000, 0x001.
- len=0 on `go[1]` → `busrq_n` stays 1; `done[1]` pulses within 2 `clk`.
- `busak_n` raised for 3 `cen` mid-XFER → no `dst_we` during the stall; the remaining words are written in order with no loss or duplication.
- `rst_n` low during XFER → `busrq_n`=1 in the same cycle; no `done`; a `go` after reset runs normally. With `JTFRAME_DMA_VBL_EN`, `go` during `LVBL`=1 → no request until `LVBL` falls.
